// File: rtl/sound_decoder.sv
// sound_decoder
// Decodes the 1-bit audio stream of a raster-timed sound generator into a
// per-line level, a half-period measurement in lines and a silence flag.
// All measurements are taken at the line end (x == H_LAST).
//
// Optional feature: define SOUND_DECODER_PEAK_EN to build a peak-hold meter
// that tracks the maximum line level and decays by 1/8 once per frame
// (at the line end of the last line, y == V_LAST). Without the macro the
// peak output is tied to zero and no peak register exists.
//
// SILENCE_LINES must lie in 2..255; it is compared against the low-run
// length, which starts at 1 and grows by one per inactive line.

module sound_decoder #(
    parameter int H_LAST        = 799,
    parameter int V_LAST        = 524,
    parameter int SILENCE_LINES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sound,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] level,
    output logic       level_valid,
    output logic [7:0] half_period,
    output logic       period_valid,
    output logic       silent,
    output logic [9:0] peak
);

    typedef enum logic [1:0] {
        ST_SILENT   = 2'd0,
        ST_HIGH_RUN = 2'd1,
        ST_LOW_RUN  = 2'd2
    } state_t;

    localparam logic [9:0] H_LAST_V        = 10'(H_LAST);
    localparam logic [8:0] SILENCE_LINES_V = 9'(SILENCE_LINES);
    localparam logic [7:0] RUN_MAX         = 8'hFF;

    // Line-level accumulator and the level it produces at the line end.
    logic [9:0] acc_q;
    logic [9:0] new_level;
    logic       line_end;
    logic       line_active;

    // Run-length FSM state.
    state_t     state_q, state_d;
    logic [7:0] run_q, run_d;
    logic [7:0] half_period_d;
    logic       period_valid_d;
    logic [8:0] run_inc;
    logic       silence_hit;

    // The sample on the line-end cycle is folded into the completed line,
    // so the captured level is the accumulator plus the current sample.
    assign line_end    = (x == H_LAST_V);
    assign new_level   = acc_q + {9'd0, sound};
    assign line_active = (new_level != 10'd0);

    // Run length one wider than the counter so the silence compare never wraps.
    assign run_inc     = {1'b0, run_q} + 9'd1;
    assign silence_hit = (run_inc == SILENCE_LINES_V);

    // Accumulate samples within a line; publish the count at the line end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= 10'd0;
            level       <= 10'd0;
            level_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so acc_q and level update together without races.
            level_valid <= line_end;
            if (line_end) begin
                level <= new_level;
                acc_q <= 10'd0;
            end else begin
                acc_q <= new_level;
            end
        end
    end

    // FSM state, run counter and half-period registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SILENT;
            run_q        <= 8'd0;
            half_period  <= 8'd0;
            period_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            half_period  <= half_period_d;
            period_valid <= period_valid_d;
        end
    end

    // Next-state logic: classify the finished line and extend or close the run.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d        = state_q;
        run_d          = run_q;
        half_period_d  = half_period;
        period_valid_d = 1'b0;

        if (line_end) begin
            case (state_q)
                ST_SILENT: begin
                    if (line_active) begin
                        state_d = ST_HIGH_RUN;
                        run_d   = 8'd1;
                    end
                end

                ST_HIGH_RUN: begin
                    if (line_active) begin
                        // Long tones saturate instead of wrapping to a short period.
                        run_d = (run_q == RUN_MAX) ? run_q : run_inc[7:0];
                    end else begin
                        half_period_d  = run_q;
                        period_valid_d = 1'b1;
                        state_d        = ST_LOW_RUN;
                        run_d          = 8'd1;
                    end
                end

                ST_LOW_RUN: begin
                    if (line_active) begin
                        half_period_d  = run_q;
                        period_valid_d = 1'b1;
                        state_d        = ST_HIGH_RUN;
                        run_d          = 8'd1;
                    end else if (silence_hit) begin
                        // A long enough quiet stretch ends the tone altogether.
                        half_period_d  = 8'd0;
                        period_valid_d = 1'b1;
                        state_d        = ST_SILENT;
                        run_d          = 8'd0;
                    end else begin
                        run_d = run_inc[7:0];
                    end
                end

                default: begin
                    state_d = ST_SILENT;
                    run_d   = 8'd0;
                end
            endcase
        end
    end

    assign silent = (state_q == ST_SILENT);

`ifdef SOUND_DECODER_PEAK_EN
    logic [9:0] peak_q;
    logic [9:0] peak_base;

    // Frame boundary decays the held peak by 1/8 before the new level is applied.
    always_comb begin
        peak_base = peak_q;
        if (y == 10'(V_LAST)) begin
            peak_base = peak_q - (peak_q >> 3);
        end
    end

    // Peak hold: keep the larger of the (possibly decayed) peak and the new level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= 10'd0;
        end else if (line_end) begin
            peak_q <= (new_level > peak_base) ? new_level : peak_base;
        end
    end

    assign peak = peak_q;
`else
    // y only feeds the frame decay of the peak meter.
    logic unused_y;
    assign unused_y = ^y;

    assign peak = 10'd0;
`endif

endmodule

// File: tb/tb_sound_decoder.sv
// Testbench for sound_decoder with a shortened raster (32 pixels per line,
// 10 lines per frame) so long run-length sequences stay short in cycles.
// Table-driven per-line vectors plus hand-written multi-line sequences.

module tb_sound_decoder;

    localparam int H_LAST = 31;
    localparam int V_LAST = 9;
`ifdef SOUND_DECODER_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       sound;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] level;
    logic       level_valid;
    logic [7:0] half_period;
    logic       period_valid;
    logic       silent;
    logic [9:0] peak;

    int errors = 0;
    int checks = 0;
    int cur_y  = 0;
    int last_y = 0;
    int lv_cnt;
    int pv_cnt;

    typedef struct {
        int start;
        int len;
        int exp_level;
        int exp_pv;
        int exp_hp;
        int exp_silent;
        int exp_peak;
    } vec_t;

    vec_t vecs[8];

    sound_decoder #(
        .H_LAST        (H_LAST),
        .V_LAST        (V_LAST),
        .SILENCE_LINES (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sound        (sound),
        .x            (x),
        .y            (y),
        .level        (level),
        .level_valid  (level_valid),
        .half_period  (half_period),
        .period_valid (period_valid),
        .silent       (silent),
        .peak         (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one full line; sound is 1 for x in [start, start+len).
    // Counts valid pulses seen after each edge; the line's own pulse is
    // visible after the final edge (the one that consumed x == H_LAST).
    task automatic drive_line(input int start, input int len);
        lv_cnt = 0;
        pv_cnt = 0;
        for (int xi = 0; xi <= H_LAST; xi++) begin
            x     = 10'(xi);
            y     = 10'(cur_y);
            sound = (xi >= start) && (xi < start + len);
            @(posedge clk);
            #1;
            lv_cnt += int'(level_valid);
            pv_cnt += int'(period_valid);
        end
        last_y = cur_y;
        cur_y  = (cur_y == V_LAST) ? 0 : cur_y + 1;
    endtask

    initial begin
        int pv_total;

        // start, len, level, pv, half_period, silent, peak(if enabled)
        vecs[0] = '{8,  8,  8,  0, 0, 0, 8};
        vecs[1] = '{0,  0,  0,  1, 1, 0, 8};
        vecs[2] = '{0,  32, 32, 1, 1, 0, 32};
        vecs[3] = '{31, 1,  1,  0, 1, 0, 32};
        vecs[4] = '{0,  1,  1,  0, 1, 0, 32};
        vecs[5] = '{0,  0,  0,  1, 3, 0, 32};
        vecs[6] = '{0,  0,  0,  0, 3, 0, 32};
        vecs[7] = '{20, 5,  5,  1, 2, 0, 32};

        // Reset with sound asserted: nothing may be counted.
        rst_n = 1'b0;
        sound = 1'b1;
        x     = 10'd0;
        y     = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", int'(level), 0);
        check("reset_level_valid", int'(level_valid), 0);
        check("reset_half_period", int'(half_period), 0);
        check("reset_period_valid", int'(period_valid), 0);
        check("reset_silent", int'(silent), 1);
        check("reset_peak", int'(peak), 0);
        rst_n = 1'b1;

        // Per-line vectors.
        for (int i = 0; i < 8; i++) begin
            drive_line(vecs[i].start, vecs[i].len);
            check($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_level);
            check($sformatf("vec%0d_lv_pulses", i), lv_cnt, 1);
            check($sformatf("vec%0d_level_valid", i), int'(level_valid), 1);
            check($sformatf("vec%0d_period_valid", i), int'(period_valid), vecs[i].exp_pv);
            check($sformatf("vec%0d_pv_pulses", i), pv_cnt, vecs[i].exp_pv);
            check($sformatf("vec%0d_half_period", i), int'(half_period), vecs[i].exp_hp);
            check($sformatf("vec%0d_silent", i), int'(silent), vecs[i].exp_silent);
            check($sformatf("vec%0d_peak", i), int'(peak), PEAK_ON ? vecs[i].exp_peak : 0);
        end

        // Square wave: close the current 1-line high run, then 30-line halves.
        drive_line(0, 0);
        check("sq_first_pv", int'(period_valid), 1);
        check("sq_first_hp", int'(half_period), 1);
        pv_total = 0;
        for (int l = 1; l < 30; l++) begin
            drive_line(0, 0);
            pv_total += pv_cnt;
        end
        check("sq_lead_pv_count", pv_total, 0);
        for (int h = 0; h < 4; h++) begin
            drive_line(0, (h % 2 == 0) ? 4 : 0);
            check($sformatf("sq_half%0d_pv", h), int'(period_valid), 1);
            check($sformatf("sq_half%0d_hp", h), int'(half_period), 30);
            pv_total = 0;
            for (int l = 1; l < 30; l++) begin
                drive_line(0, (h % 2 == 0) ? 4 : 0);
                pv_total += pv_cnt;
            end
            check($sformatf("sq_half%0d_pv_count", h), pv_total, 0);
            check($sformatf("sq_half%0d_silent", h), int'(silent), 0);
        end

        // Silence: 30 inactive lines already done; 224 more stay in the low run.
        pv_total = 0;
        for (int l = 0; l < 224; l++) begin
            drive_line(0, 0);
            pv_total += pv_cnt;
        end
        check("sil_pre_pv_count", pv_total, 0);
        check("sil_pre_silent", int'(silent), 0);
        drive_line(0, 0);
        check("sil_enter_silent", int'(silent), 1);
        check("sil_enter_pv", int'(period_valid), 1);
        check("sil_enter_hp", int'(half_period), 0);
        drive_line(0, 0);
        check("sil_hold_silent", int'(silent), 1);
        check("sil_hold_pv_count", pv_cnt, 0);
        drive_line(10, 3);
        check("sil_exit_silent", int'(silent), 0);
        check("sil_exit_pv_count", pv_cnt, 0);
        check("sil_exit_level", int'(level), 3);

        // Saturation: 300 active lines in total, then one inactive line.
        pv_total = 0;
        for (int l = 0; l < 299; l++) begin
            drive_line(5, 1);
            pv_total += pv_cnt;
        end
        check("sat_pv_count", pv_total, 0);
        drive_line(0, 0);
        check("sat_close_pv", int'(period_valid), 1);
        check("sat_close_hp", int'(half_period), 255);

        // Reset in the middle of a line with sound held high.
        for (int xi = 0; xi <= H_LAST; xi++) begin
            x     = 10'(xi);
            y     = 10'(cur_y);
            sound = 1'b1;
            rst_n = (xi != 16);
            @(posedge clk);
            #1;
            if (xi == 16) begin
                check("mid_rst_level", int'(level), 0);
                check("mid_rst_level_valid", int'(level_valid), 0);
                check("mid_rst_half_period", int'(half_period), 0);
                check("mid_rst_period_valid", int'(period_valid), 0);
                check("mid_rst_silent", int'(silent), 1);
                check("mid_rst_peak", int'(peak), 0);
            end
        end
        rst_n  = 1'b1;
        last_y = cur_y;
        cur_y  = (cur_y == V_LAST) ? 0 : cur_y + 1;
        check("post_rst_level", int'(level), 15);
        check("post_rst_level_valid", int'(level_valid), 1);
        check("post_rst_silent", int'(silent), 0);
        check("post_rst_pv", int'(period_valid), 0);

        // Peak hold and per-frame decay (constant zero when disabled).
        drive_line(0, 32);
        check("peak_full", int'(peak), PEAK_ON ? 32 : 0);
        for (int l = 0; l < 12; l++) begin
            drive_line(0, 0);
            if (last_y == V_LAST) begin
                check("peak_decay", int'(peak), PEAK_ON ? 28 : 0);
                break;
            end
            check($sformatf("peak_hold%0d", l), int'(peak), PEAK_ON ? 32 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
